// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor configuration sequencer: state encoding,
// register map indices, mode encodings and control-word helpers.
package proc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIS,
      ST_WR_K,
      ST_WR_C,
      ST_VFY,
      ST_RUN,
      ST_STOP,
      ST_FAIL
   } seq_state_e;

   localparam logic [4:0] REG_CTRL = 5'd0;
   localparam logic [4:0] REG_K0   = 5'd1;
   localparam int         NUM_K    = 9;

   localparam logic [1:0] MODE_BYPASS = 2'b00;
   localparam logic [1:0] MODE_INVERT = 2'b01;
   localparam logic [1:0] MODE_CONV   = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   // Control register layout: bit 7 enable, bits 1:0 mode.
   function automatic logic [7:0] ctrl_word(input logic en, input logic [1:0] mode);
      return {en, 5'b0, mode};
   endfunction

   function automatic logic [7:0] kernel_byte(input logic [71:0] k, input logic [3:0] i);
      return k[{i, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/proc_cfg_sequencer.sv
// Programs the pixel processor (disable, kernel, enable), reads the registers back,
// then runs one frame until the requested number of output pulses or an abort.
module proc_cfg_sequencer
   import proc_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       cfg_mode,
   input  logic [71:0]      cfg_kernel,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             reg_write_en,
   output logic [4:0]       reg_addr,
   output logic [7:0]       reg_wdata,
   input  logic [7:0]       reg_rdata,
   input  logic             proc_valid,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] pix_count
);

   seq_state_e       state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [1:0]       mode_q, mode_d;
   logic [71:0]      kernel_q, kernel_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] pix_q, pix_d;
   logic             cmpl_q, cmpl_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic [CNT_W:0]   pix_sum;
   logic [7:0]       vfy_exp;

   // One extra bit lets the saturation and the end-of-frame compare share one adder.
   assign pix_sum = {1'b0, pix_q} + {{CNT_W{1'b0}}, proc_valid};
   assign vfy_exp = (idx_q == 4'd0) ? ctrl_word(1'b1, mode_q)
                                    : kernel_byte(kernel_q, idx_q - 4'd1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         mode_q   <= '0;
         kernel_q <= '0;
         count_q  <= '0;
         pix_q    <= '0;
         cmpl_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         mode_q   <= mode_d;
         kernel_q <= kernel_d;
         count_q  <= count_d;
         pix_q    <= pix_d;
         cmpl_q   <= cmpl_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mode_d       = mode_q;
      kernel_d     = kernel_q;
      count_d      = count_q;
      pix_d        = pix_q;
      cmpl_d       = cmpl_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      reg_write_en = 1'b0;
      reg_addr     = '0;
      reg_wdata    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_mode == MODE_RSVD || cfg_count == '0) begin
                  error_d = 1'b1;
               end else begin
                  mode_d   = cfg_mode;
                  kernel_d = cfg_kernel;
                  count_d  = cfg_count;
                  pix_d    = '0;
                  cmpl_d   = 1'b0;
                  idx_d    = '0;
                  state_d  = ST_DIS;
               end
            end
         end
         ST_DIS: begin
            reg_write_en = 1'b1;
            reg_addr     = REG_CTRL;
            reg_wdata    = ctrl_word(1'b0, MODE_BYPASS);
            idx_d        = '0;
            state_d      = ST_WR_K;
         end
         ST_WR_K: begin
            reg_write_en = 1'b1;
            reg_addr     = REG_K0 + {1'b0, idx_q};
            reg_wdata    = kernel_byte(kernel_q, idx_q);
            if (idx_q == 4'(NUM_K - 1)) begin
               idx_d   = '0;
               state_d = ST_WR_C;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         ST_WR_C: begin
            reg_write_en = 1'b1;
            reg_addr     = REG_CTRL;
            reg_wdata    = ctrl_word(1'b1, mode_q);
            idx_d        = '0;
            state_d      = ST_VFY;
         end
         ST_VFY: begin
            reg_addr = {1'b0, idx_q};
            if (reg_rdata != vfy_exp) begin
               state_d = ST_FAIL;
            end else if (idx_q == 4'(NUM_K)) begin
               idx_d   = '0;
               state_d = ST_RUN;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         ST_RUN: begin
            pix_d = pix_sum[CNT_W] ? '1 : pix_sum[CNT_W-1:0];
            // Abort wins over a simultaneous final pulse; the pulse is still counted.
            if (abort) begin
               cmpl_d  = 1'b0;
               state_d = ST_STOP;
            end else if (pix_sum == {1'b0, count_q}) begin
               cmpl_d  = 1'b1;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            reg_write_en = 1'b1;
            reg_addr     = REG_CTRL;
            reg_wdata    = ctrl_word(1'b0, mode_q);
            done_d       = cmpl_q;
            state_d      = ST_IDLE;
         end
         ST_FAIL: begin
            reg_write_en = 1'b1;
            reg_addr     = REG_CTRL;
            reg_wdata    = ctrl_word(1'b0, MODE_BYPASS);
            error_d      = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign pix_count = pix_q;

endmodule

// File: tb/tb_proc_cfg_sequencer.sv
// Scoreboard bench for proc_cfg_sequencer: frames are issued with random data,
// expected register writes and done/error pulses are queued and matched by a monitor.
module tb_proc_cfg_sequencer;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [1:0]       cfg_mode = '0;
   logic [71:0]      cfg_kernel = '0;
   logic [CNT_W-1:0] cfg_count = '0;
   logic             reg_write_en;
   logic [4:0]       reg_addr;
   logic [7:0]       reg_wdata;
   logic [7:0]       reg_rdata;
   logic             proc_valid = 1'b0;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] pix_count;

   int n_checks = 0;
   int n_pass   = 0;

   wr_t        exp_wr[$];
   logic [1:0] exp_evt[$];   // {done, error}

   logic [7:0] regs [0:9];
   bit         fault_en = 1'b0;

   always #5 clk = ~clk;

   proc_cfg_sequencer #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .abort       (abort),
      .cfg_mode    (cfg_mode),
      .cfg_kernel  (cfg_kernel),
      .cfg_count   (cfg_count),
      .reg_write_en(reg_write_en),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_rdata   (reg_rdata),
      .proc_valid  (proc_valid),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .pix_count   (pix_count)
   );

   // Processor register file with optional corrupted readback at address 5.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 10; i++) regs[i] <= 8'h00;
      end else if (reg_write_en && reg_addr < 5'd10) begin
         regs[reg_addr[3:0]] <= reg_wdata;
      end
   end

   always_comb begin
      reg_rdata = 8'h00;
      if (fault_en && reg_addr == 5'd5) reg_rdata = 8'h07;
      else if (reg_addr < 5'd10)        reg_rdata = regs[reg_addr[3:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic note_fail(input string name, input logic [31:0] act);
      n_checks++;
      $display("FAIL %s: got 0x%0h with nothing expected", name, act);
   endtask

   task automatic push_wr(input int a, input logic [7:0] d);
      wr_t w;
      w.addr = 5'(a);
      w.data = d;
      exp_wr.push_back(w);
   endtask

   // Monitor: every write and every done/error pulse must match the head of its queue.
   always @(negedge clk) begin
      if (rstn) begin
         if (reg_write_en) begin
            if (exp_wr.size() == 0) begin
               note_fail("unexpected_write", {19'b0, reg_addr, reg_wdata});
            end else begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("write", {19'b0, reg_addr, reg_wdata}, {19'b0, w.addr, w.data});
            end
         end
         if (done || error) begin
            if (exp_evt.size() == 0) begin
               note_fail("unexpected_pulse", {30'b0, done, error});
            end else begin
               logic [1:0] e;
               e = exp_evt.pop_front();
               chk("done_error", {30'b0, done, error}, {30'b0, e});
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_we"},    reg_write_en, 0);
      chk({tag, "_addr"},  reg_addr, 0);
      chk({tag, "_wdata"}, reg_wdata, 0);
      chk({tag, "_pix"},   pix_count, 0);
   endtask

   // abort_at < 0: no abort; rst_at < 0: no reset during RUN.
   task automatic run_frame(input logic [1:0] mode, input logic [71:0] kern, input int cnt,
                            input int abort_at, input bit abort_pv, input bit fault,
                            input bit start_busy, input int rst_at);
      logic [7:0] ref_rb [10];
      int pulses;
      int exp_pix;
      bit was_reset;
      was_reset = 1'b0;
      exp_pix   = 0;

      push_wr(0, 8'h00);
      ref_rb[0] = {1'b1, 5'b0, mode};
      for (int k = 1; k <= 9; k++) begin
         ref_rb[k] = kern[8*(k-1) +: 8];
         push_wr(k, ref_rb[k]);
      end
      push_wr(0, ref_rb[0]);
      if (fault) begin
         push_wr(0, 8'h00);
         exp_evt.push_back(2'b01);
      end else if (rst_at < 0) begin
         push_wr(0, {1'b0, 5'b0, mode});
         if (abort_at >= 0) begin
            exp_pix = abort_at + int'(abort_pv);
         end else begin
            exp_pix = cnt;
            exp_evt.push_back(2'b10);
         end
      end

      fault_en   = fault;
      cfg_mode   = mode;
      cfg_kernel = kern;
      cfg_count  = CNT_W'(cnt);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      cfg_mode   = 2'($urandom);
      cfg_kernel = {8'($urandom), 32'($urandom), 32'($urandom)};
      cfg_count  = CNT_W'($urandom);

      // Programming and readback: pulses and aborts here must be ignored.
      for (int c = 1; c <= 21; c++) begin
         proc_valid = 1'($urandom);
         abort      = 1'($urandom);
         @(negedge clk);
         if (c >= 12) begin
            chk("vfy_addr", reg_addr, c - 12);
            chk("vfy_we", reg_write_en, 0);
            chk("vfy_rdata", reg_rdata, (fault && c == 17) ? 8'h07 : ref_rb[c-12]);
         end
         @(posedge clk); #1;
         if (fault && c == 17) break;
      end
      proc_valid = 1'b0;
      abort      = 1'b0;

      if (!fault) begin
         pulses = 0;
         for (int cyc = 0; cyc < 400; cyc++) begin
            if (rst_at >= 0 && cyc == rst_at) begin
               #2 rstn = 1'b0;
               #1 check_all_zero("rst_run");
               @(posedge clk); #1 rstn = 1'b1;
               fault_en  = 1'b0;
               was_reset = 1'b1;
               break;
            end
            if (abort_at >= 0 && pulses == abort_at) begin
               abort      = 1'b1;
               proc_valid = abort_pv;
               @(posedge clk); #1;
               abort      = 1'b0;
               proc_valid = 1'b0;
               break;
            end
            proc_valid = 1'($urandom);
            start      = start_busy && cyc == 1;
            @(posedge clk); #1;
            start = 1'b0;
            if (proc_valid) pulses++;
            proc_valid = 1'b0;
            if (abort_at < 0 && rst_at < 0 && pulses == cnt) break;
         end
      end

      for (int w = 0; w < 40; w++) begin
         proc_valid = 1'($urandom);
         @(negedge clk);
         if (!busy) break;
         @(posedge clk); #1;
      end
      chk("frame_end_busy", busy, 0);
      chk(was_reset ? "pix_after_reset" : "pix_count", pix_count, exp_pix);
      proc_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("stays_idle", busy, 0);
      chk("pix_held", pix_count, exp_pix);
      chk("writes_drained", exp_wr.size(), 0);
      chk("pulses_drained", exp_evt.size(), 0);
      fault_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reject(input logic [1:0] mode, input int cnt);
      exp_evt.push_back(2'b01);
      cfg_mode  = mode;
      cfg_count = CNT_W'(cnt);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("rej_busy", busy, 0);
      chk("rej_error", error, 1);
      @(negedge clk);
      chk("rej_busy_after", busy, 0);
      chk("rej_error_once", error, 0);
      chk("rej_no_write", exp_wr.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [71:0] kern;
      logic [71:0] ident;
      ident = '0;
      ident[39:32] = 8'h01;

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;

      kern = {8'($urandom), 32'($urandom), 32'($urandom)};
      run_frame(2'b00, kern, 4, -1, 1'b0, 1'b0, 1'b0, -1);
      run_frame(2'b10, ident, 5, -1, 1'b0, 1'b0, 1'b0, -1);
      run_frame(2'b01, ident, 5, -1, 1'b0, 1'b1, 1'b0, -1);
      reject(2'b11, 5);
      reject(2'b01, 0);
      kern = {8'($urandom), 32'($urandom), 32'($urandom)};
      run_frame(2'b01, kern, 10, 2, 1'b0, 1'b0, 1'b1, -1);
      kern = {8'($urandom), 32'($urandom), 32'($urandom)};
      run_frame(2'b10, kern, 3, 2, 1'b1, 1'b0, 1'b0, -1);
      kern = {8'($urandom), 32'($urandom), 32'($urandom)};
      run_frame(2'b00, kern, 10, -1, 1'b0, 1'b0, 1'b0, 3);
      kern = {8'($urandom), 32'($urandom), 32'($urandom)};
      run_frame(2'b10, kern, 1, -1, 1'b0, 1'b0, 1'b0, -1);

      for (int f = 0; f < 8; f++) begin
         int cnt;
         int ab;
         cnt  = 1 + int'($urandom_range(0, 6));
         kern = {8'($urandom), 32'($urandom), 32'($urandom)};
         ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
         if ($urandom_range(0, 4) == 0) reject(2'b11, cnt);
         run_frame(2'($urandom_range(0, 2)), kern, cnt, ab, 1'($urandom), 1'b0, 1'b0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
